// File: rtl/bcd_sec_counter_pkg.sv
// Shared definitions for the two-digit BCD seconds counter: FSM state
// encodings, digit width and the load-value validity check.
package bcd_sec_counter_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // A load value is usable only if both nibbles are decimal digits and the
    // number they form lies inside the count range 0..modulus-1.
    function automatic logic bcd_load_ok(input logic [7:0] value, input int modulus);
        int number;
        number = int'(value[7:4]) * 10 + int'(value[3:0]);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (number < modulus);
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational next-value generator for a two-digit BCD modulo counter.
// Produces the value one step up or down from {tens,ones}, and flags the
// modulus wrap (MOD-1 -> 00 going up, 00 -> MOD-1 going down).
module bcd_step
    import bcd_sec_counter_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic [DIGIT_W-1:0] tens,
    input  logic [DIGIT_W-1:0] ones,
    input  logic               dir,
    output logic [DIGIT_W-1:0] next_tens,
    output logic [DIGIT_W-1:0] next_ones,
    output logic               wrap
);

    // Digits of the top of the count range (MOD-1).
    localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'((MOD - 1) / 10);
    localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'((MOD - 1) % 10);

    // Next value: wrap at the range ends, otherwise decimal carry/borrow.
    always_comb begin
        next_tens = tens;
        next_ones = ones;
        wrap      = 1'b0;
        if (dir) begin
            if (tens == MAX_TENS && ones == MAX_ONES) begin
                next_tens = '0;
                next_ones = '0;
                wrap      = 1'b1;
            end else if (ones == 4'd9) begin
                next_ones = '0;
                next_tens = tens + 4'd1;
            end else begin
                next_ones = ones + 4'd1;
            end
        end else begin
            if (tens == 4'd0 && ones == 4'd0) begin
                next_tens = MAX_TENS;
                next_ones = MAX_ONES;
                wrap      = 1'b1;
            end else if (ones == 4'd0) begin
                next_ones = 4'd9;
                next_tens = tens - 4'd1;
            end else begin
                next_ones = ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_sec_counter.sv
// Two-digit BCD modulo counter with run/pause/clear control. Steps once per
// rising edge of the 1 Hz divider output while running; supports parallel
// BCD load with range checking.
module bcd_sec_counter
    import bcd_sec_counter_pkg::*;
#(
    parameter int MOD      = 60,
    parameter bit UP_RESET = 1'b1
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               tick_in,
    input  logic               start_stop,
    input  logic               clear,
    input  logic               load,
    input  logic [7:0]         load_val,
    input  logic               dir,
    output logic [DIGIT_W-1:0] bcd_tens,
    output logic [DIGIT_W-1:0] bcd_ones,
    output logic               running,
    output logic               wrap,
    output logic               load_err
);

    state_t             state_reg, state_next;
    logic               tick_d_reg;
    logic               dir_primed_reg;
    logic [DIGIT_W-1:0] tens_reg, tens_next;
    logic [DIGIT_W-1:0] ones_reg, ones_next;
    logic               wrap_reg, wrap_next;
    logic               load_err_reg, load_err_next;
    logic               running_reg;

    logic               step;
    logic               dir_eff;
    logic               load_ok;
    logic [DIGIT_W-1:0] step_tens, step_ones;
    logic               step_wrap;

    // Rising edge of the tick while running; edges outside RUN are simply lost.
    assign step    = tick_in & ~tick_d_reg & (state_reg == ST_RUN);
    // Until dir has been sampled once after reset, use the reset direction.
    assign dir_eff = dir_primed_reg ? dir : UP_RESET;
    assign load_ok = bcd_load_ok(load_val, MOD);

    bcd_step #(
        .MOD (MOD)
    ) u_step (
        .tens      (tens_reg),
        .ones      (ones_reg),
        .dir       (dir_eff),
        .next_tens (step_tens),
        .next_ones (step_ones),
        .wrap      (step_wrap)
    );

    // Run/pause FSM: clear dominates start_stop.
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_IDLE;
        end else if (start_stop) begin
            case (state_reg)
                ST_IDLE:  state_next = ST_RUN;
                ST_RUN:   state_next = ST_PAUSE;
                ST_PAUSE: state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Count update with priority clear > load > step; pulses default low.
    always_comb begin
        tens_next     = tens_reg;
        ones_next     = ones_reg;
        wrap_next     = 1'b0;
        load_err_next = 1'b0;
        if (clear) begin
            tens_next = '0;
            ones_next = '0;
        end else if (load) begin
            if (load_ok) begin
                tens_next = load_val[7:4];
                ones_next = load_val[3:0];
            end else begin
                load_err_next = 1'b1;
            end
        end else if (step) begin
            tens_next = step_tens;
            ones_next = step_ones;
            wrap_next = step_wrap;
        end
    end

    // State, edge-detector and output registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            tick_d_reg     <= 1'b0;
            dir_primed_reg <= 1'b0;
            tens_reg       <= '0;
            ones_reg       <= '0;
            wrap_reg       <= 1'b0;
            load_err_reg   <= 1'b0;
            running_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tick_d_reg     <= tick_in;
            dir_primed_reg <= 1'b1;
            tens_reg       <= tens_next;
            ones_reg       <= ones_next;
            wrap_reg       <= wrap_next;
            load_err_reg   <= load_err_next;
            running_reg    <= (state_next == ST_RUN);
        end
    end

    assign bcd_tens = tens_reg;
    assign bcd_ones = ones_reg;
    assign running  = running_reg;
    assign wrap     = wrap_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_sec_counter.sv
// Scoreboard bench for bcd_sec_counter (MOD=60): directed scenarios followed
// by randomized traffic, checked against an integer-valued reference model.
module tb_bcd_sec_counter;

    localparam int MOD = 60;

    logic       clk_in;
    logic       rst_n;
    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       dir;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       running;
    logic       wrap;
    logic       load_err;

    bcd_sec_counter #(
        .MOD      (MOD),
        .UP_RESET (1'b1)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .dir        (dir),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones),
        .running    (running),
        .wrap       (wrap),
        .load_err   (load_err)
    );

    typedef struct {
        string      name;
        logic [3:0] t;
        logic [3:0] o;
        logic       run;
        logic       wr;
        logic       lerr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: count as a plain integer, state as 0=idle 1=run 2=pause.
    int   m_cnt   = 0;
    int   m_state = 0;
    bit   m_tick  = 0;
    bit   cur_dir = 1;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Monitor: after each active edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bcd_tens !== e.t || bcd_ones !== e.o || running !== e.run ||
                    wrap !== e.wr || load_err !== e.lerr) begin
                    errors++;
                    $display("FAIL %s: got %0d%0d run=%0b wrap=%0b lerr=%0b, expected %0d%0d run=%0b wrap=%0b lerr=%0b",
                             e.name, bcd_tens, bcd_ones, running, wrap, load_err,
                             e.t, e.o, e.run, e.wr, e.lerr);
                end else begin
                    $display("ok   %s: %0d%0d run=%0b wrap=%0b lerr=%0b",
                             e.name, bcd_tens, bcd_ones, running, wrap, load_err);
                end
            end
        end
    end

    // Apply one cycle of stimulus and push the model's expected result.
    task automatic drive(input bit rst, input bit ss, input bit clr, input bit ld,
                         input logic [7:0] lv, input bit d, input bit tk, input string nm);
        exp_t e;
        int   lt, lo, ns;
        bit   rise;
        @(negedge clk_in);
        rst_n = rst; start_stop = ss; clear = clr; load = ld;
        load_val = lv; dir = d; tick_in = tk;
        e.name = nm; e.wr = 1'b0; e.lerr = 1'b0;
        if (!rst) begin
            m_cnt = 0; m_state = 0; m_tick = 0;
        end else begin
            rise   = tk && !m_tick && (m_state == 1);
            m_tick = tk;
            ns = m_state;
            if (clr) ns = 0;
            else if (ss) ns = (m_state == 1) ? 2 : 1;
            if (clr) begin
                m_cnt = 0;
            end else if (ld) begin
                lt = int'(lv[7:4]);
                lo = int'(lv[3:0]);
                if (lt <= 9 && lo <= 9 && lt * 10 + lo < MOD) m_cnt = lt * 10 + lo;
                else e.lerr = 1'b1;
            end else if (rise) begin
                if (d) begin
                    e.wr  = (m_cnt == MOD - 1);
                    m_cnt = (m_cnt + 1) % MOD;
                end else begin
                    e.wr  = (m_cnt == 0);
                    m_cnt = (m_cnt + MOD - 1) % MOD;
                end
            end
            m_state = ns;
        end
        e.t   = 4'(m_cnt / 10);
        e.o   = 4'(m_cnt % 10);
        e.run = (m_state == 1);
        q.push_back(e);
    endtask

    task automatic idle(input int n, input string nm);
        repeat (n) drive(1, 0, 0, 0, 8'h00, cur_dir, 0, nm);
    endtask

    task automatic press(input string nm);
        drive(1, 1, 0, 0, 8'h00, cur_dir, 0, nm);
    endtask

    task automatic do_load(input logic [7:0] v, input string nm);
        drive(1, 0, 0, 1, v, cur_dir, 0, nm);
    endtask

    // One full tick period: high (edge seen) then low.
    task automatic tick_up(input string nm);
        drive(1, 0, 0, 0, 8'h00, cur_dir, 1, nm);
        drive(1, 0, 0, 0, 8'h00, cur_dir, 0, nm);
    endtask

    // Drop rst_n between clock edges and check outputs clear without a clock.
    task automatic async_reset(input string nm);
        @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bcd_tens !== 4'd0 || bcd_ones !== 4'd0 || running !== 1'b0 ||
            wrap !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: got %0d%0d run=%0b wrap=%0b lerr=%0b, expected 00 run=0 wrap=0 lerr=0",
                     nm, bcd_tens, bcd_ones, running, wrap, load_err);
        end else begin
            $display("ok   %s: async clear to 00", nm);
        end
        m_cnt = 0; m_state = 0; m_tick = 0;
        drive(0, 0, 0, 0, 8'h00, cur_dir, 0, {nm, "_held"});
        drive(1, 0, 0, 0, 8'h00, cur_dir, 0, {nm, "_release"});
    endtask

    initial begin
        int half;
        int phase;
        bit tk;
        bit ss, clr, ld;
        logic [7:0] lv;
        int v;

        rst_n = 1'b0; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0;
        load = 1'b0; load_val = 8'h00; dir = 1'b1;

        drive(0, 0, 0, 0, 8'h00, 1, 0, "reset");
        drive(0, 0, 0, 0, 8'h00, 1, 0, "reset");
        drive(1, 0, 0, 0, 8'h00, 1, 0, "reset_release");

        // Count up three ticks from zero.
        cur_dir = 1;
        press("s1_start");
        tick_up("s1_tick1");
        tick_up("s1_tick2");
        tick_up("s1_tick3");

        // Wrap upward from 59.
        do_load(8'h59, "s2_load59");
        tick_up("s2_wrap_up");
        idle(1, "s2_wrap_gone");

        // Wrap downward from 00, then borrow from 10.
        drive(1, 0, 1, 0, 8'h00, 1, 0, "s3_clear");
        press("s3_start");
        cur_dir = 0;
        tick_up("s3_wrap_down");
        do_load(8'h10, "s3_load10");
        tick_up("s3_borrow");
        cur_dir = 1;
        do_load(8'h19, "s3_load19");
        tick_up("s3_carry");

        // Pause holds and edges during pause are never replayed.
        do_load(8'h07, "s4_load07");
        press("s4_pause");
        tick_up("s4_pause_tick1");
        drive(1, 0, 0, 0, 8'h00, 1, 1, "s4_pause_tick_hi");
        drive(1, 1, 0, 0, 8'h00, 1, 1, "s4_resume_tick_hi");
        drive(1, 0, 0, 0, 8'h00, 1, 1, "s4_no_catchup");
        drive(1, 0, 0, 0, 8'h00, 1, 0, "s4_tick_lo");
        tick_up("s4_next_step");

        // Rejected loads, then load colliding with a step.
        do_load(8'h6A, "s5_reject_6A");
        idle(1, "s5_lerr_gone");
        do_load(8'h60, "s5_reject_60");
        do_load(8'h3C, "s5_reject_3C");
        drive(1, 0, 0, 1, 8'h25, 1, 1, "s5_load_beats_step");
        drive(1, 0, 0, 1, 8'hF0, 1, 0, "s5_bad_load_no_step");
        tick_up("s5_after");

        // Clear beats start_stop; asynchronous reset while running.
        do_load(8'h42, "s6_load42");
        drive(1, 1, 1, 0, 8'h00, 1, 0, "s6_clear_and_ss");
        idle(1, "s6_idle_tick_ignored");
        press("s6_start");
        tick_up("s6_tick");
        tick_up("s6_tick");
        async_reset("s6_async_reset");
        tick_up("s6_idle_after_reset");

        // Randomized traffic: tick as a square wave with random half-period.
        half = 2; phase = 0; tk = 0;
        for (int i = 0; i < 800; i++) begin
            if (phase >= half) begin
                tk    = ~tk;
                phase = 0;
                half  = $urandom_range(1, 4);
            end
            phase++;
            if ($urandom_range(0, 19) == 0) cur_dir = ~cur_dir;
            ss  = ($urandom_range(0, 11) == 0);
            clr = ($urandom_range(0, 79) == 0);
            ld  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 0) begin
                lv = 8'($urandom_range(0, 255));
            end else begin
                v  = $urandom_range(0, MOD - 1);
                lv = {4'(v / 10), 4'(v % 10)};
            end
            drive(1, ss, clr, ld, lv, cur_dir, tk, "rand");
            if (i == 400) async_reset("rand_async_reset");
        end
        idle(2, "final");

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk_in);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
